bram_client_port: RTL

- Initiator-side adapter that drives one port of the team's dual-port write-first BRAM (EN/WE/ADDR/DI in, DO out).
- Converts a valid/ready request stream into BRAM port cycles.
- Tracks the fixed BRAM read latency and captures read data into a small response FIFO with valid/ready backpressure.
- Sits between cache/tag-array control logic and a BRAM2 instance; one instance per BRAM port used.

---
 rtl/bram_client_port.sv | 97 +++++++++
 1 files changed

// File: rtl/bram_client_port.sv
// Valid/ready front end for one port of a write-first BRAM: drives EN/WE/ADDR/DI,
// tracks the fixed read latency and queues read data behind a credit-limited FIFO.
// Optional: define BRAM_CLIENT_WRITE_ACK_EN to make writes return their echo as a response.
module bram_client_port #(
  parameter int ADDR_WIDTH = 9,
  parameter int DATA_WIDTH = 64,
  parameter int PIPELINED  = 0,
  parameter int RESP_DEPTH = 4
) (
  input  logic                  CLK,
  input  logic                  RST_N,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [DATA_WIDTH-1:0] resp_data,
  output logic                  bram_en,
  output logic                  bram_we,
  output logic [ADDR_WIDTH-1:0] bram_addr,
  output logic [DATA_WIDTH-1:0] bram_di,
  input  logic [DATA_WIDTH-1:0] bram_do
);
  localparam int LAT = 1 + PIPELINED;
  localparam int AW  = $clog2(RESP_DEPTH);
  localparam int CW  = $clog2(RESP_DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(RESP_DEPTH);

  logic [CW-1:0]         count_q, count_d;
  logic [LAT-1:0]        tag_q, tag_d;
  logic [AW:0]           wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] mem_q [RESP_DEPTH];
  logic                  accept, rsp_prod, push, pop, fifo_full;

`ifdef BRAM_CLIENT_WRITE_ACK_EN
  assign rsp_prod = 1'b1;
`else
  assign rsp_prod = ~req_write;
`endif

  // Credits cover both in-flight reads and queued data, so the FIFO can never overflow.
  assign req_ready = (count_q < DEPTH_C);
  assign accept    = req_valid & req_ready;

  assign bram_en   = accept;
  assign bram_we   = accept & req_write;
  assign bram_addr = req_addr;
  assign bram_di   = req_data;

  assign push       = tag_q[LAT-1];
  assign resp_valid = (wr_ptr_q != rd_ptr_q);
  assign pop        = resp_valid & resp_ready;
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign resp_data  = mem_q[rd_ptr_q[AW-1:0]];

  always_comb begin
    tag_d    = '0;
    tag_d[0] = accept & rsp_prod;
    for (int i = 1; i < LAT; i++) tag_d[i] = tag_q[i-1];

    count_d = count_q;
    case ({tag_d[0], pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      count_q  <= '0;
      tag_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      tag_q    <= tag_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge CLK) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bram_do;
  end

  a_no_overflow: assert property (@(posedge CLK) disable iff (!RST_N) !(push && fifo_full));
  a_count_range: assert property (@(posedge CLK) disable iff (!RST_N) count_q <= DEPTH_C);

endmodule
